// File: rtl/mont_reduce_scheduler_pkg.sv
// Shared types for the Montgomery-reduce scheduler: FSM states, requester ids
// and the width helper for beat counters.
package mont_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int REQ_COUNT = 2;

  typedef logic [$clog2(REQ_COUNT)-1:0] req_id_t;

  // Wide enough to hold a count equal to n, not just n-1.
  function automatic int beat_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mont_reduce_scheduler_indexer.sv
// Constant-ROM block address sequencer. The address leads the registered index
// by one on a consume so a synchronous ROM has the next block ready.
module const_block_indexer #(
  parameter  int CONST_BLOCKS = 128,
  localparam int AW           = $clog2(CONST_BLOCKS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          consumed_in,
  input  logic          clear_in,
  output logic [AW-1:0] rd_addr_out
);

  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_inc;

  assign idx_inc     = (idx_q == AW'(CONST_BLOCKS - 1)) ? '0 : idx_q + 1'b1;
  assign rd_addr_out = consumed_in ? idx_inc : idx_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        idx_q <= '0;
    else if (clear_in) idx_q <= '0;
    else               idx_q <= rd_addr_out;
  end

endmodule

// File: rtl/mont_reduce_scheduler.sv
// Round-robin arbiter sharing one Montgomery-reduce datapath between two
// requesters: forwards T blocks, sequences k/N ROM addresses, returns results.
module mont_reduce_scheduler
  import mont_sched_pkg::*;
#(
  parameter  int REGISTER_SIZE = 32,
  parameter  int NUM_BLOCKS    = 256,
  parameter  int CONST_BLOCKS  = 128,
  localparam int AW            = $clog2(CONST_BLOCKS)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [REQ_COUNT-1:0]                req_in,
  output logic [REQ_COUNT-1:0]                grant_out,
  input  logic [REQ_COUNT-1:0]                t_valid_in,
  input  logic [REQ_COUNT*REGISTER_SIZE-1:0]  t_block_in,
  output logic                                mr_valid_out,
  output logic [REGISTER_SIZE-1:0]            mr_T_block_out,
  input  logic                                consumed_k_in,
  input  logic                                consumed_N_in,
  output logic [AW-1:0]                       k_rd_addr_out,
  output logic [AW-1:0]                       n_rd_addr_out,
  input  logic                                mr_valid_in,
  input  logic [REGISTER_SIZE-1:0]            mr_data_in,
  input  logic                                mr_final_in,
  output logic [REQ_COUNT-1:0]                res_valid_out,
  output logic [REGISTER_SIZE-1:0]            res_data_out,
  output logic                                res_final_out,
  output logic                                busy_out,
  output logic                                err_out
);

  localparam int            CW       = beat_cnt_w(NUM_BLOCKS);
  localparam logic [CW-1:0] LAST_T   = CW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(NUM_BLOCKS / 2 - 1);

  state_e                   state_q, state_d;
  req_id_t                  ptr_q, ptr_d, gid_q, gid_d, nxt_id;
  logic [REQ_COUNT-1:0]     grant_q, grant_d, res_valid_q, res_valid_d;
  logic [CW-1:0]            beat_q, beat_d, res_cnt_q, res_cnt_d;
  logic                     mr_valid_q, mr_valid_d, res_final_q, res_final_d;
  logic                     err_q, err_d, clear_idx, active;
  logic [REGISTER_SIZE-1:0] mr_t_q, mr_t_d, res_data_q, res_data_d, t_blk;

  assign active = (state_q != IDLE);
  assign t_blk  = t_block_in[gid_q*REGISTER_SIZE +: REGISTER_SIZE];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    nxt_id      = ptr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    res_cnt_d   = res_cnt_q;
    mr_valid_d  = 1'b0;
    mr_t_d      = mr_t_q;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    res_final_d = 1'b0;
    err_d       = err_q;
    clear_idx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mr_valid_in) err_d = 1'b1;
        if (|req_in) begin
          nxt_id          = req_in[ptr_q] ? ptr_q : ~ptr_q;
          gid_d           = nxt_id;
          grant_d         = '0;
          grant_d[nxt_id] = 1'b1;
          beat_d          = '0;
          res_cnt_d       = '0;
          clear_idx       = 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        if (mr_valid_in) err_d = 1'b1;
        if (t_valid_in[gid_q]) begin
          mr_valid_d = 1'b1;
          mr_t_d     = t_blk;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_T) state_d = RUN;
        end
      end
      RUN: begin
        // Surplus T beats are dropped; the datapath already has its full job.
        if (t_valid_in[gid_q]) err_d = 1'b1;
        if (mr_valid_in) begin
          res_valid_d[gid_q] = 1'b1;
          res_data_d         = mr_data_in;
          res_final_d        = mr_final_in;
          if (res_cnt_q != '1) res_cnt_d = res_cnt_q + 1'b1;
          if (mr_final_in) begin
            if (res_cnt_q != RES_LAST) err_d = 1'b1;
            grant_d = '0;
            ptr_d   = ~gid_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      grant_q     <= '0;
      beat_q      <= '0;
      res_cnt_q   <= '0;
      mr_valid_q  <= 1'b0;
      mr_t_q      <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_final_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      res_cnt_q   <= res_cnt_d;
      mr_valid_q  <= mr_valid_d;
      mr_t_q      <= mr_t_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_final_q <= res_final_d;
      err_q       <= err_d;
    end
  end

  const_block_indexer #(.CONST_BLOCKS(CONST_BLOCKS)) u_k_idx (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .consumed_in (consumed_k_in & active),
    .clear_in    (clear_idx),
    .rd_addr_out (k_rd_addr_out)
  );

  const_block_indexer #(.CONST_BLOCKS(CONST_BLOCKS)) u_n_idx (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .consumed_in (consumed_N_in & active),
    .clear_in    (clear_idx),
    .rd_addr_out (n_rd_addr_out)
  );

  assign grant_out      = grant_q;
  assign mr_valid_out   = mr_valid_q;
  assign mr_T_block_out = mr_t_q;
  assign res_valid_out  = res_valid_q;
  assign res_data_out   = res_data_q;
  assign res_final_out  = res_final_q;
  assign busy_out       = active;
  assign err_out        = err_q;

endmodule

// File: tb/tb_mont_reduce_scheduler.sv
// Directed bench for mont_reduce_scheduler with scoreboard queues for the
// forwarded T stream and the returned result stream.
module tb_mont_reduce_scheduler;

  localparam int RS = 8;
  localparam int NB = 8;
  localparam int CB = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [1:0]    req_in = '0;
  logic [1:0]    grant_out;
  logic [1:0]    t_valid_in = '0;
  logic [2*RS-1:0] t_block_in = '0;
  logic          mr_valid_out;
  logic [RS-1:0] mr_T_block_out;
  logic          consumed_k_in = 1'b0;
  logic          consumed_N_in = 1'b0;
  logic [1:0]    k_rd_addr_out;
  logic [1:0]    n_rd_addr_out;
  logic          mr_valid_in = 1'b0;
  logic [RS-1:0] mr_data_in = '0;
  logic          mr_final_in = 1'b0;
  logic [1:0]    res_valid_out;
  logic [RS-1:0] res_data_out;
  logic          res_final_out;
  logic          busy_out;
  logic          err_out;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  tq[$];
  logic [10:0] rq[$];

  mont_reduce_scheduler #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .CONST_BLOCKS(CB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .grant_out(grant_out),
    .t_valid_in(t_valid_in), .t_block_in(t_block_in),
    .mr_valid_out(mr_valid_out), .mr_T_block_out(mr_T_block_out),
    .consumed_k_in(consumed_k_in), .consumed_N_in(consumed_N_in),
    .k_rd_addr_out(k_rd_addr_out), .n_rd_addr_out(n_rd_addr_out),
    .mr_valid_in(mr_valid_in), .mr_data_in(mr_data_in), .mr_final_in(mr_final_in),
    .res_valid_out(res_valid_out), .res_data_out(res_data_out),
    .res_final_out(res_final_out), .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and any
  // forwarded beat is popped from its scoreboard.
  task automatic tick();
    logic [7:0]  et;
    logic [10:0] er;
    @(posedge clk_in); #1;
    if (mr_valid_out) begin
      check("t_expected", 32'(tq.size() != 0), 1);
      if (tq.size() != 0) begin
        et = tq.pop_front();
        check("t_block", mr_T_block_out, et);
      end
    end
    if (res_valid_out != 2'b00) begin
      check("res_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        er = rq.pop_front();
        check("res_beat", {res_valid_out, res_final_out, res_data_out}, er);
      end
    end
  endtask

  task automatic start(input logic [1:0] rv, input logic [1:0] exp_g);
    req_in = rv;
    tick();
    check("grant", grant_out, exp_g);
    check("busy_on_grant", busy_out, 1);
    check("k_addr_on_grant", k_rd_addr_out, 0);
    check("n_addr_on_grant", n_rd_addr_out, 0);
  endtask

  // Beats for requester r; the other requester is driven with junk that
  // must be ignored.
  task automatic load_job(input int r, input logic [7:0] base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i == 3) tick();
      t_valid_in[r] = 1'b1;
      t_block_in[r*RS +: RS] = base + 8'(i);
      tq.push_back(base + 8'(i));
      t_valid_in[1-r] = 1'b1;
      t_block_in[(1-r)*RS +: RS] = 8'hEE;
      tick();
      t_valid_in = '0;
    end
    check("t_drain", tq.size(), 0);
  endtask

  task automatic results(input int r, input logic [7:0] base, input int n);
    logic [1:0] oh;
    oh = 2'b01 << r;
    for (int i = 0; i < n; i++) begin
      mr_valid_in = 1'b1;
      mr_data_in  = base + 8'(i);
      mr_final_in = (i == n - 1);
      rq.push_back({oh, mr_final_in, mr_data_in});
      tick();
      mr_valid_in = 1'b0;
      mr_final_in = 1'b0;
    end
    check("res_drain", rq.size(), 0);
    check("busy_after_final", busy_out, 0);
    check("grant_after_final", grant_out, 0);
  endtask

  task automatic sync_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  initial begin
    int ke[6];
    ke = '{1, 2, 3, 0, 1, 2};

    // Reset state
    tick(); tick();
    check("rst_grant", grant_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_err", err_out, 0);
    check("rst_mr_valid", mr_valid_out, 0);
    check("rst_res_valid", res_valid_out, 0);
    check("rst_k_addr", k_rd_addr_out, 0);
    check("rst_n_addr", n_rd_addr_out, 0);
    rst_in = 1'b0;
    tick();

    // Requester 0 alone; request dropped mid-job, gap in T beats
    start(2'b01, 2'b01);
    req_in = 2'b00;
    load_job(0, 8'h10, NB, 1'b1);
    check("busy_in_run", busy_out, 1);
    for (int i = 0; i < 6; i++) begin
      consumed_k_in = 1'b1; #1;
      check("k_addr_pulse", k_rd_addr_out, ke[i]);
      tick();
    end
    consumed_k_in = 1'b0; #1;
    check("k_idx_after", k_rd_addr_out, 2);
    tick();
    check("k_idx_hold", k_rd_addr_out, 2);
    consumed_N_in = 1'b1; #1;
    check("n_addr_pulse", n_rd_addr_out, 1);
    tick();
    consumed_N_in = 1'b0;
    results(0, 8'hA0, NB/2);
    check("res_final_last", res_final_out, 1);
    check("err_clean_job", err_out, 0);

    // Asynchronous reset in the middle of LOAD
    start(2'b01, 2'b01);
    req_in = 2'b00;
    consumed_k_in = 1'b1;
    load_job(0, 8'h20, 5, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    check("async_mr_valid", mr_valid_out, 0);
    check("async_grant", grant_out, 0);
    check("async_busy", busy_out, 0);
    check("async_k_addr", k_rd_addr_out, 0);
    check("async_t_block", mr_T_block_out, 0);
    tick();
    rst_in = 1'b0;
    consumed_k_in = 1'b0;
    tick();

    // Both request: pointer is back at 0, then requester 1 follows
    start(2'b11, 2'b01);
    load_job(0, 8'h30, NB, 1'b0);
    results(0, 8'hB0, NB/2);
    tick();
    check("grant_second", grant_out, 2'b10);
    req_in = 2'b01;
    load_job(1, 8'h50, NB, 1'b0);
    results(1, 8'hC0, NB/2);
    req_in = 2'b00;
    check("err_after_pair", err_out, 0);

    // Short result stream
    tick();
    start(2'b01, 2'b01);
    req_in = 2'b00;
    load_job(0, 8'h60, NB, 1'b0);
    results(0, 8'hD0, 3);
    check("err_short_final", err_out, 1);
    tick();
    check("err_sticky", err_out, 1);
    sync_reset();
    check("err_cleared", err_out, 0);

    // Result beat while IDLE
    mr_valid_in = 1'b1;
    mr_data_in  = 8'h77;
    tick();
    mr_valid_in = 1'b0;
    check("err_idle_result", err_out, 1);
    check("idle_result_dropped", res_valid_out, 0);
    sync_reset();

    // Surplus T beat in RUN is dropped
    start(2'b10, 2'b10);
    req_in = 2'b00;
    load_job(1, 8'h70, NB, 1'b0);
    check("err_before_extra", err_out, 0);
    t_valid_in[1] = 1'b1;
    t_block_in[RS +: RS] = 8'h99;
    tick();
    t_valid_in = '0;
    tick();
    check("err_extra_t", err_out, 1);
    check("extra_t_dropped", mr_valid_out, 0);
    results(1, 8'hE0, NB/2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mont_reduce_scheduler.md
Name: mont_reduce_scheduler

Overview:
- Shares one Montgomery-reduce datapath between two requesters, e.g. two multiplier streams of the encryption pipeline.
- Grants the datapath round-robin and forwards the winner's T block stream.
- Sequences the k and N constant-ROM read addresses from the datapath's consumed strobes.
- Routes the reduced result stream back to the granted requester; one job is in flight at a time.

Parameters:
- REGISTER_SIZE, 32, bits per block.
- NUM_BLOCKS, 256, T blocks per job; the result is NUM_BLOCKS/2 blocks.
- CONST_BLOCKS, 128, blocks in each of the k and N constants (R/REGISTER_SIZE).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- req_in  in  2  job request per requester.
- grant_out  out  2  one-hot grant, held for the whole job.
- t_valid_in  in  2  T block valid per requester.
- t_block_in  in  2*REGISTER_SIZE  T blocks; requester i occupies slice [i*REGISTER_SIZE +: REGISTER_SIZE].
- mr_valid_out  out  1  T valid to the datapath.
- mr_T_block_out  out  REGISTER_SIZE  T block to the datapath.
- consumed_k_in  in  1  datapath consumed a k block.
- consumed_N_in  in  1  datapath consumed an N block.
- k_rd_addr_out  out  $clog2(CONST_BLOCKS)  k ROM read address.
- n_rd_addr_out  out  $clog2(CONST_BLOCKS)  N ROM read address.
- mr_valid_in  in  1  result block valid.
- mr_data_in  in  REGISTER_SIZE  result block.
- mr_final_in  in  1  last result block, coincident with its valid.
- res_valid_out  out  2  per-requester result valid.
- res_data_out  out  REGISTER_SIZE  result block.
- res_final_out  out  1  last result block.
- busy_out  out  1  state is not IDLE.
- err_out  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset (asynchronous, any time, including mid-job):
  - state goes to IDLE; round-robin pointer goes to 0.
  - All outputs go to 0; both address indices go to 0.
- State machine:
  - IDLE: if any req_in is high, grant the requester selected by the pointer (pointer index first, then the other). grant_out is asserted the next cycle and state goes to LOAD. Both address indices clear to 0 on grant.
  - LOAD: forward the granted requester's t_valid and t_block through a register (1-cycle latency to mr_valid_out and mr_T_block_out). Count the beats. On beat NUM_BLOCKS-1, go to RUN.
  - RUN: forward each mr_valid_in beat through a register (1 cycle) to res_valid_out[granted], res_data_out and res_final_out. Count result beats.
  - On a forwarded mr_final_in: drop the grant the next cycle, flip the pointer to the other requester, return to IDLE.
- Address sequencing (one const_block_indexer per constant):
  - rd_addr_out is combinational: idx+1 when consumed is high, otherwise idx. This lets a 1-cycle synchronous ROM present the next block the cycle after the consume.
  - idx registers rd_addr_out.
  - Wraps CONST_BLOCKS-1 to 0; N is re-read for the multiply, compare and subtract passes.
  - Consumes are counted only in LOAD and RUN.
- Boundary conditions:
  - req_in dropped during LOAD or RUN is ignored; the job completes.
  - t_valid_in from the non-granted requester is ignored.
  - t_valid_in from the granted requester in RUN (beat beyond NUM_BLOCKS) is dropped and sets err_out.
  - mr_valid_in in IDLE or LOAD is dropped and sets err_out.
  - mr_final_in with a result count other than NUM_BLOCKS/2 sets err_out; the job still terminates.
  - A requester re-requesting immediately after its own job loses to a pending other requester.
  - Gaps in t_valid are allowed; counting is per beat.

Decomposition:
- Package mont_sched_pkg holds:
  - state enum: IDLE, LOAD, RUN.
  - REQ_COUNT=2 and the requester-id type.
  - the beat-count width function.
- Sub-module const_block_indexer (parameters CONST_BLOCKS; ports consumed_in, clear_in, rd_addr_out), instantiated for k and N.

Test Plan (REGISTER_SIZE=8, NUM_BLOCKS=8, CONST_BLOCKS=4):
- req_in=01, eight T beats 0x10..0x17 -> grant_out=01 at +1 cycle; mr_T_block_out shows 0x10..0x17 each one cycle late; state RUN after the 8th beat.
- req_in=11 from IDLE after reset -> requester 0 is granted. After its mr_final_in, requester 1 is granted 2 cycles later and its results appear only on res_valid_out[1].
- Six consumed_k pulses -> k_rd_addr_out reads 1,2,3,0,1,2 in the same cycles as the pulses; idx is 2 afterward. No change when consumed is low.
- Four result beats 0xA0..0xA3 with final on 0xA3 -> res_data_out 0xA0..0xA3 each one cycle late; res_final_out with 0xA3; busy_out low the next cycle; err_out stays 0.
- mr_valid_in in IDLE, or final after 3 beats -> err_out=1 and stays 1 until rst_in.
- rst_in asserted mid-LOAD after 5 beats -> all outputs 0 asynchronously; a new req starts a fresh count and addresses at 0.
